// File: rtl/result_collector.sv
// Result collector: shifts and narrows accumulator results, buffers them in a FWFT FIFO
// and re-emits them with a per-vector last flag. Define RESULT_SAT_EN for saturating narrowing.
module result_collector #(
  parameter int ACC_W   = 24,
  parameter int OUT_W   = 8,
  parameter int SHIFT   = 8,
  parameter int VEC_LEN = 8,
  parameter int DEPTH   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ACC_W-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic [15:0]      vec_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(VEC_LEN);

  logic [OUT_W-1:0] data_mem_r [DEPTH];
  logic [DEPTH-1:0] last_mem_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [IDX_W-1:0] idx_r;
  logic [15:0]      vec_count_r;
  logic             in_ready_r;
  logic             out_valid_r;

  logic                    push_s;
  logic                    pop_s;
  logic [CNT_W-1:0]        count_nxt_s;
  logic signed [ACC_W-1:0] shifted_s;
  logic [OUT_W-1:0]        narrow_s;
  logic                    last_s;

  // Narrow a shifted accumulator value to the output element width.
  function automatic logic [OUT_W-1:0] narrow_elem(input logic signed [ACC_W-1:0] s);
    logic [OUT_W-1:0] r;
`ifdef RESULT_SAT_EN
    logic signed [ACC_W-1:0] sat_max;
    logic signed [ACC_W-1:0] sat_min;
    sat_max = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    sat_min = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    if (s > sat_max) begin
      r = {1'b0, {(OUT_W-1){1'b1}}};
    end else if (s < sat_min) begin
      r = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      r = s[OUT_W-1:0];
    end
`else
    r = s[OUT_W-1:0];
`endif
    return r;
  endfunction

  // Handshake qualification, element conversion and next occupancy.
  always_comb begin
    push_s    = in_valid && in_ready_r;
    pop_s     = out_valid_r && out_ready;
    shifted_s = $signed(in_data) >>> SHIFT;
    narrow_s  = narrow_elem(shifted_s);
    last_s    = (idx_r == IDX_W'(VEC_LEN - 1));
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_W'(1);
      2'b01:   count_nxt_s = count_r - CNT_W'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // FIFO storage, pointers, occupancy and registered flow-control flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_mem_r[i] <= '0;
      end
      last_mem_r  <= '0;
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      count_r     <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      if (push_s) begin
        data_mem_r[wr_ptr_r] <= narrow_s;
        last_mem_r[wr_ptr_r] <= last_s;
        wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r     <= count_nxt_s;
      // Flags come from the next occupancy so neither depends combinationally on out_ready.
      in_ready_r  <= (count_nxt_s < CNT_W'(DEPTH));
      out_valid_r <= (count_nxt_s != CNT_W'(0));
    end
  end

  // Element index within the current vector and completed-vector counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_r       <= '0;
      vec_count_r <= 16'd0;
    end else begin
      if (push_s) begin
        if (last_s) begin
          idx_r <= '0;
        end else begin
          idx_r <= idx_r + IDX_W'(1);
        end
      end
      if (pop_s && last_mem_r[rd_ptr_r]) begin
        vec_count_r <= vec_count_r + 16'd1;
      end
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = data_mem_r[rd_ptr_r];
  assign out_last  = last_mem_r[rd_ptr_r];
  assign vec_count = vec_count_r;

endmodule

// File: tb/tb_result_collector.sv
// Directed self-checking bench for result_collector (default parameters).
module tb_result_collector;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic [15:0] vec_count;

  int vectors     = 0;
  int miscompares = 0;

  result_collector dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .vec_count (vec_count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Eight back-to-back elements of one value, consumer always ready.
  task automatic run_vector(input logic [23:0] d, input logic [7:0] exp, input logic [15:0] exp_cnt);
    in_valid  = 1'b1;
    in_data   = d;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_val("vec_valid", out_valid, 1'b1);
      check_val("vec_data", out_data, exp);
      check_val("vec_last", out_last, (i == 7));
    end
    in_valid = 1'b0;
    tick();
    check_val("vec_count", vec_count, exp_cnt);
    check_val("vec_drained", out_valid, 1'b0);
  endtask

  logic [23:0] conv_in  [6];
  logic [7:0]  conv_exp [6];

  initial begin
    rst       = 1'b0;
    in_data   = 24'h0;
    in_valid  = 1'b0;
    out_ready = 1'b0;

    conv_in[0] = 24'h000180; conv_exp[0] = 8'h01;
    conv_in[1] = 24'hFFFF00; conv_exp[1] = 8'hFF;
    conv_in[2] = 24'hFF8000; conv_exp[2] = 8'h80;
`ifdef RESULT_SAT_EN
    conv_in[3] = 24'h7FFFFF; conv_exp[3] = 8'h7F;
    conv_in[4] = 24'h800000; conv_exp[4] = 8'h80;
    conv_in[5] = 24'h012345; conv_exp[5] = 8'h7F;
`else
    conv_in[3] = 24'h7FFFFF; conv_exp[3] = 8'hFF;
    conv_in[4] = 24'h800000; conv_exp[4] = 8'h00;
    conv_in[5] = 24'h012345; conv_exp[5] = 8'h23;
`endif

    // Reset state
    do_reset();
    check_val("rst_valid", out_valid, 1'b0);
    check_val("rst_last", out_last, 1'b0);
    check_val("rst_data", out_data, 8'h00);
    check_val("rst_ready", in_ready, 1'b1);
    check_val("rst_count", vec_count, 16'h0000);

    // First vector of 0x000180 -> 0x01
    run_vector(24'h000180, 8'h01, 16'd1);

    // Conversion table, one element at a time
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1;
      in_data  = conv_in[k];
      tick();
      in_valid = 1'b0;
      check_val("conv_valid", out_valid, 1'b1);
      check_val("conv_data", out_data, conv_exp[k]);
      tick();
      check_val("conv_empty", out_valid, 1'b0);
    end

    // Fill with consumer stalled: four accepted, then in_ready drops
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int c = 0; c < 6; c++) begin
      in_data = 24'((c + 1) << 8);
      check_val("fill_ready", in_ready, (c < 4));
      tick();
      check_val("fill_head", out_data, 8'h01);
    end
    check_val("full_ready", in_ready, 1'b0);
    // Pop while full with a pending push: the push must be refused
    in_data   = 24'h000500;
    out_ready = 1'b1;
    check_val("full_head", out_data, 8'h01);
    tick();
    in_valid = 1'b0;
    check_val("pop_ready", in_ready, 1'b1);
    for (int j = 2; j <= 4; j++) begin
      check_val("order_valid", out_valid, 1'b1);
      check_val("order_data", out_data, 8'(j));
      tick();
    end
    check_val("order_empty", out_valid, 1'b0);

    // Steady stream: 16 vectors, one element per cycle
    do_reset();
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int e = 0; e < 128; e++) begin
      in_data = 24'(e << 8);
      tick();
      check_val("strm_data", out_data, 8'(e));
      check_val("strm_last", out_last, ((e % 8) == 7));
      check_val("strm_ready", in_ready, 1'b1);
      check_val("strm_count", vec_count, 16'(e / 8));
    end
    in_valid = 1'b0;
    tick();
    check_val("strm_total", vec_count, 16'd16);
    check_val("strm_empty", out_valid, 1'b0);

    // Mid-operation reset: 5 pushed, 3 still buffered
    in_valid  = 1'b1;
    out_ready = 1'b0;
    in_data   = 24'h000300;
    tick(); tick(); tick();
    out_ready = 1'b1;
    tick(); tick();
    check_val("pre_rst_valid", out_valid, 1'b1);
    check_val("pre_rst_ready", in_ready, 1'b1);
    in_valid = 1'b0;
    do_reset();
    check_val("mid_rst_valid", out_valid, 1'b0);
    check_val("mid_rst_count", vec_count, 16'h0000);
    check_val("mid_rst_data", out_data, 8'h00);
    check_val("mid_rst_last", out_last, 1'b0);
    check_val("mid_rst_ready", in_ready, 1'b1);
    run_vector(24'hFFFE00, 8'hFE, 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
